// File: rtl/sim_exit_ctrl.sv
// Simulation exit controller: a small register slave that lets software or a cycle
// watchdog request the end of simulation and report an exit code.
module sim_exit_ctrl #(
  parameter logic [31:0] TIMEOUT_CODE = 32'hFFFF_FFFF,
  parameter int unsigned ADDR_W       = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  output logic              gnt_o,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              we_i,
  input  logic [3:0]        be_i,
  input  logic [31:0]       wdata_i,
  output logic              rvalid_o,
  output logic [31:0]       rdata_o,
  output logic              exit_valid_o,
  output logic [31:0]       exit_value_o
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 64;

  localparam logic [2:0] IDX_EXIT_CTRL  = 3'd0;
  localparam logic [2:0] IDX_EXIT_VALUE = 3'd1;
  localparam logic [2:0] IDX_CYCLE_LO   = 3'd2;
  localparam logic [2:0] IDX_CYCLE_HI   = 3'd3;
  localparam logic [2:0] IDX_MAXCYCLES  = 3'd4;
  localparam logic [2:0] IDX_STATUS     = 3'd5;

  logic [CNT_W-1:0]  r_cycle;
  logic [DATA_W-1:0] r_snap_hi;
  logic [DATA_W-1:0] r_exit_value;
  logic [DATA_W-1:0] r_maxcycles;
  logic              r_exit_valid;
  logic              r_timeout;
  logic              r_rvalid;
  logic [DATA_W-1:0] r_rdata;

  logic [2:0]        w_idx;
  logic              w_wr;
  logic              w_rd;
  logic              w_sw_exit;
  logic              w_timeout;
  logic [DATA_W-1:0] w_mask;
  logic [DATA_W-1:0] w_rdata;
  logic              w_addr_unused;

  assign w_idx         = addr_i[4:2];
  assign w_addr_unused = ^{addr_i[ADDR_W-1:5], addr_i[1:0]};
  assign w_wr          = req_i & we_i;
  assign w_rd          = req_i & ~we_i;
  assign w_mask        = {{8{be_i[3]}}, {8{be_i[2]}}, {8{be_i[1]}}, {8{be_i[0]}}};
  assign w_sw_exit     = w_wr && (w_idx == IDX_EXIT_CTRL) && be_i[0] && wdata_i[0];
  assign w_timeout     = (r_maxcycles != '0) && (r_cycle[DATA_W-1:0] >= r_maxcycles)
                         && !r_exit_valid;

  // Read data selection; EXIT_CTRL and unmapped words read as zero
  always_comb begin
    w_rdata = '0;
    unique case (w_idx)
      IDX_EXIT_VALUE: w_rdata = r_exit_value;
      IDX_CYCLE_LO:   w_rdata = r_cycle[DATA_W-1:0];
      IDX_CYCLE_HI:   w_rdata = r_snap_hi;
      IDX_MAXCYCLES:  w_rdata = r_maxcycles;
      IDX_STATUS:     w_rdata = DATA_W'({r_timeout, r_exit_valid});
      default:        w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cycle      <= '0;
      r_snap_hi    <= '0;
      r_exit_value <= '0;
      r_maxcycles  <= '0;
      r_exit_valid <= 1'b0;
      r_timeout    <= 1'b0;
      r_rvalid     <= 1'b0;
      r_rdata      <= '0;
    end else begin
      r_cycle  <= r_cycle + CNT_W'(1);
      r_rvalid <= req_i;
      r_rdata  <= w_rd ? w_rdata : '0;

      // Reading the low word latches the high word so a LO/HI pair is coherent
      if (w_rd && (w_idx == IDX_CYCLE_LO)) begin
        r_snap_hi <= r_cycle[CNT_W-1:DATA_W];
      end

      if (w_wr && (w_idx == IDX_MAXCYCLES)) begin
        r_maxcycles <= (r_maxcycles & ~w_mask) | (wdata_i & w_mask);
      end

      // Software exit beats the watchdog; once exited, value and cause are frozen
      if (!r_exit_valid) begin
        if (w_sw_exit) begin
          r_exit_valid <= 1'b1;
        end else if (w_timeout) begin
          r_exit_valid <= 1'b1;
          r_timeout    <= 1'b1;
          r_exit_value <= TIMEOUT_CODE;
        end else if (w_wr && (w_idx == IDX_EXIT_VALUE)) begin
          r_exit_value <= (r_exit_value & ~w_mask) | (wdata_i & w_mask);
        end
      end
    end
  end

  assign gnt_o        = req_i;
  assign rvalid_o     = r_rvalid;
  assign rdata_o      = r_rdata;
  assign exit_valid_o = r_exit_valid;
  assign exit_value_o = r_exit_value;

endmodule

// File: tb/tb_sim_exit_ctrl.sv
// Directed bench for sim_exit_ctrl: register access, software exit, watchdog
// timeout, exit/timeout priority, coherent counter reads and mid-transaction reset.
module tb_sim_exit_ctrl;

  localparam int unsigned ADDR_W = 32;
  localparam logic [2:0] I_CTRL = 3'd0;
  localparam logic [2:0] I_VAL  = 3'd1;
  localparam logic [2:0] I_LO   = 3'd2;
  localparam logic [2:0] I_HI   = 3'd3;
  localparam logic [2:0] I_MAX  = 3'd4;
  localparam logic [2:0] I_STAT = 3'd5;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              req_i = 1'b0;
  logic              gnt_o;
  logic [ADDR_W-1:0] addr_i = '0;
  logic              we_i = 1'b0;
  logic [3:0]        be_i = '0;
  logic [31:0]       wdata_i = '0;
  logic              rvalid_o;
  logic [31:0]       rdata_o;
  logic              exit_valid_o;
  logic [31:0]       exit_value_o;

  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned tb_cyc  = 0;
  int unsigned last_cyc = 0;
  logic [31:0] d;

  sim_exit_ctrl #(.TIMEOUT_CODE(32'hFFFF_FFFF), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o),
    .addr_i(addr_i), .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i),
    .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .exit_valid_o(exit_valid_o), .exit_value_o(exit_value_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model of the free-running cycle counter
  always @(posedge clk_i) begin
    if (rst_i) tb_cyc <= 0;
    else       tb_cyc <= tb_cyc + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus(input logic w, input logic [2:0] idx, input logic [3:0] be,
                     input logic [31:0] wd, output logic [31:0] rd);
    @(negedge clk_i);
    last_cyc = tb_cyc;
    req_i = 1'b1; we_i = w; addr_i = ADDR_W'({idx, 2'b00}); be_i = be; wdata_i = wd;
    @(negedge clk_i);
    req_i = 1'b0; we_i = 1'b0; be_i = '0; wdata_i = '0;
    rd = rdata_o;
    check("rvalid", 64'(rvalid_o), 64'd1);
  endtask

  task automatic wr(input logic [2:0] idx, input logic [3:0] be, input logic [31:0] wd);
    logic [31:0] dummy;
    bus(1'b1, idx, be, wd, dummy);
  endtask

  task automatic rd(input logic [2:0] idx, output logic [31:0] v);
    bus(1'b0, idx, 4'hF, 32'h0, v);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1; req_i = 1'b1; we_i = 1'b0; addr_i = ADDR_W'(32'h8);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0; req_i = 1'b0;
  endtask

  task automatic wait_cyc(input int unsigned target);
    int g = 0;
    while (tb_cyc != target && g < 400) begin
      @(negedge clk_i);
      g++;
    end
    check("wait_bound", 64'(tb_cyc), 64'(target));
  endtask

  initial begin
    // Reset state, including a request granted during reset
    rst_i = 1'b1; req_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check("gnt_in_reset", 64'(gnt_o), 64'd1);
    rst_i = 1'b0; req_i = 1'b0;
    check("rst_rvalid", 64'(rvalid_o), 64'd0);
    check("rst_rdata", 64'(rdata_o), 64'd0);
    check("rst_exit_valid", 64'(exit_valid_o), 64'd0);
    check("rst_exit_value", 64'(exit_value_o), 64'd0);
    @(negedge clk_i);
    check("no_rsp_after_rst", 64'(rvalid_o), 64'd0);

    // Byte-enabled writes and plain register reads
    wr(I_VAL, 4'b0010, 32'hAABB_CCDD);
    rd(I_VAL, d);       check("partial_ev", 64'(d), 64'h0000_CC00);
    rd(I_MAX, d);       check("max_rst", 64'(d), 64'h0);
    wr(I_MAX, 4'b1111, 32'h1234_5678);
    wr(I_MAX, 4'b0101, 32'hFFFF_FFFF);
    rd(I_MAX, d);       check("max_partial", 64'(d), 64'h12FF_56FF);
    wr(I_MAX, 4'b1111, 32'h0);
    rd(3'd6, d);        check("unmapped_rd", 64'(d), 64'h0);
    wr(3'd7, 4'b1111, 32'hFFFF_FFFF);
    rd(I_CTRL, d);      check("ctrl_rd", 64'(d), 64'h0);
    rd(I_LO, d);        check("cyc_lo", 64'(d), 64'(last_cyc));
    @(negedge clk_i);   check("rvalid_one_cycle", 64'(rvalid_o), 64'd0);

    // Non-qualifying EXIT_CTRL writes do nothing
    wr(I_CTRL, 4'b1111, 32'h0000_0002);
    wr(I_CTRL, 4'b1110, 32'hFFFF_FFFF);
    rd(I_STAT, d);      check("ctrl_noeffect", 64'(d), 64'h0);

    // Software exit with success code, then frozen value
    wr(I_VAL, 4'b1111, 32'h0);
    wr(I_CTRL, 4'b0001, 32'h1);
    check("sw_exit_valid", 64'(exit_valid_o), 64'd1);
    check("sw_exit_value", 64'(exit_value_o), 64'h0);
    rd(I_STAT, d);      check("sw_status", 64'(d), 64'h1);
    wr(I_VAL, 4'b1111, 32'h33);
    rd(I_VAL, d);       check("ev_frozen", 64'(d), 64'h0);

    // Watchdog timeout at MAXCYCLES=100
    do_reset();
    wr(I_MAX, 4'b1111, 32'd100);
    wait_cyc(100);
    check("to_not_yet", 64'(exit_valid_o), 64'd0);
    @(negedge clk_i);
    check("to_exit_valid", 64'(exit_valid_o), 64'd1);
    check("to_exit_value", 64'(exit_value_o), 64'hFFFF_FFFF);
    rd(I_STAT, d);      check("to_status", 64'(d), 64'h3);

    // Software exit lands on the same edge as the timeout
    do_reset();
    wr(I_VAL, 4'b1111, 32'd5);
    wr(I_MAX, 4'b1111, 32'd40);
    wait_cyc(40);
    check("race_pre", 64'(exit_valid_o), 64'd0);
    req_i = 1'b1; we_i = 1'b1; addr_i = ADDR_W'(32'h0); be_i = 4'hF; wdata_i = 32'h1;
    @(negedge clk_i);
    req_i = 1'b0; we_i = 1'b0;
    check("race_valid", 64'(exit_valid_o), 64'd1);
    check("race_value", 64'(exit_value_o), 64'd5);
    rd(I_STAT, d);      check("race_status", 64'(d), 64'h1);

    // Coherent 64-bit counter read across the low-word boundary
    do_reset();
    @(negedge clk_i);
    force dut.r_cycle = 64'h0000_0000_FFFF_FFFF;
    req_i = 1'b1; we_i = 1'b0; addr_i = ADDR_W'({I_LO, 2'b00});
    @(negedge clk_i);
    req_i = 1'b0;
    release dut.r_cycle;
    check("force_lo", 64'(rdata_o), 64'hFFFF_FFFF);
    rd(I_HI, d);        check("force_hi", 64'(d), 64'h0);

    // Load state, then reset in the cycle after a granted read
    wr(I_VAL, 4'b1111, 32'd9);
    wr(I_MAX, 4'b1111, 32'hFFFF_0000);
    @(negedge clk_i);
    force dut.r_cycle = 64'h0000_0003_0000_0010;
    req_i = 1'b1; we_i = 1'b0; addr_i = ADDR_W'({I_LO, 2'b00});
    @(negedge clk_i);
    req_i = 1'b0;
    release dut.r_cycle;
    rd(I_HI, d);        check("snap_hi", 64'(d), 64'h3);
    @(negedge clk_i);
    req_i = 1'b1; we_i = 1'b0; addr_i = ADDR_W'({I_VAL, 2'b00});
    @(negedge clk_i);
    req_i = 1'b0;
    check("pre_rst_rvalid", 64'(rvalid_o), 64'd1);
    check("pre_rst_rdata", 64'(rdata_o), 64'd9);
    rst_i = 1'b1;
    @(negedge clk_i);
    check("mid_rst_rvalid", 64'(rvalid_o), 64'd0);
    check("mid_rst_rdata", 64'(rdata_o), 64'd0);
    rst_i = 1'b0;
    rd(I_VAL, d);       check("post_ev", 64'(d), 64'h0);
    rd(I_MAX, d);       check("post_max", 64'(d), 64'h0);
    rd(I_STAT, d);      check("post_status", 64'(d), 64'h0);
    rd(I_HI, d);        check("post_snap", 64'(d), 64'h0);
    rd(I_LO, d);        check("post_lo", 64'(d), 64'(last_cyc));
    check("post_exit_valid", 64'(exit_valid_o), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sim_exit_ctrl.md
SIM_EXIT_CTRL -- requirements
Module: sim_exit_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CODE, default 32'hFFFF_FFFF: exit value reported on a watchdog timeout.
REQ-002 SHALL have parameter ADDR_W, default 32: width of the bus address.
REQ-003 SHALL have port clk_i  in  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_i  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port req_i  in  1  bus request.
REQ-006 SHALL have port gnt_o  out  1  bus grant.
REQ-007 SHALL have port addr_i  in  ADDR_W  byte address; only bits [4:2] are decoded.
REQ-008 SHALL have port we_i  in  1  1 = write, 0 = read.
REQ-009 SHALL have port be_i  in  4  byte enables for writes.
REQ-010 SHALL have port wdata_i  in  32  write data.
REQ-011 SHALL have port rvalid_o  out  1  response valid.
REQ-012 SHALL have port rdata_o  out  32  read data.
REQ-013 SHALL have port exit_valid_o  out  1  simulation end request, consumed by the testbench top.
REQ-014 SHALL have port exit_value_o  out  32  exit code; 0 means success.

Function
REQ-015 SHALL drive gnt_o = req_i combinationally; there is no backpressure.
REQ-016 SHALL assert rvalid_o for exactly one cycle, in the cycle after each granted request, for both reads and writes.
REQ-017 SHALL register rdata_o alongside rvalid_o, and SHALL drive rdata_o to 0 whenever rvalid_o = 0.
REQ-018 SHALL decode this register map, by word index:
- 0 EXIT_CTRL (W)
- 1 EXIT_VALUE (RW)
- 2 CYCLE_LO (R)
- 3 CYCLE_HI (R)
- 4 MAXCYCLES (RW)
- 5 STATUS (R): bit0 = exit_valid, bit1 = timeout
- 6..7 unmapped
REQ-019 SHALL apply writes to EXIT_VALUE and MAXCYCLES per byte according to be_i.
REQ-020 SHALL set exit_valid sticky on a write to EXIT_CTRL with be_i[0]=1 and wdata_i[0]=1; any other write to EXIT_CTRL has no effect.
REQ-021 SHALL ignore writes to read-only or unmapped words, still return rvalid_o, and return 0 on reads of EXIT_CTRL or unmapped words.
REQ-022 SHALL keep a 64-bit free-running cycle counter that increments every cycle after reset and wraps from 2^64-1 to 0.
REQ-023 SHALL, on a read of CYCLE_LO, return the low word and capture the high word into a snapshot register; a read of CYCLE_HI SHALL return that snapshot.
REQ-024 SHALL treat the watchdog as disabled while MAXCYCLES = 0.
REQ-025 SHALL, while MAXCYCLES != 0 and the counter's low 32 bits >= MAXCYCLES with exit_valid = 0, on the next edge: set exit_valid, set the timeout flag, and load EXIT_VALUE with TIMEOUT_CODE.
REQ-026 SHALL, once exit_valid = 1, freeze EXIT_VALUE and the timeout flag; later writes to them are ignored until reset.
REQ-027 SHALL give the software event priority when a software exit write and a timeout occur in the same cycle: the timeout flag stays 0 and EXIT_VALUE keeps the software value.
REQ-028 SHALL, when one write sets exit_valid while EXIT_VALUE is written in the same cycle, leave EXIT_VALUE at its previously stored value.
REQ-029 SHALL drive exit_valid_o from the exit_valid flop and exit_value_o from EXIT_VALUE continuously, with zero added latency.

Reset
REQ-030 SHALL, when rst_i = 1 at an edge, clear all of: counter, snapshot, EXIT_VALUE, MAXCYCLES, exit_valid, timeout flag, rvalid_o, rdata_o.
REQ-031 SHALL drop a response that is pending when reset arrives mid-transaction: rvalid_o = 0 in the next cycle.
REQ-032 SHALL keep gnt_o = req_i during reset, but requests granted during reset SHALL get no response.

Verification
REQ-033 SHALL cover: write EXIT_VALUE=0, then EXIT_CTRL=1 -> exit_valid_o=1 the next cycle, exit_value_o=0, STATUS reads 0x1.
REQ-034 SHALL cover: MAXCYCLES=100 with no exit write -> exit_valid_o rises one edge after the counter reaches 100, exit_value_o=0xFFFFFFFF, STATUS=0x3.
REQ-035 SHALL cover: EXIT_VALUE=5 and an EXIT_CTRL write landing in the same cycle as the timeout -> exit_value_o=5, STATUS=0x1.
REQ-036 SHALL cover: a partial write with be_i=4'b0010 and wdata_i=0xAABBCCDD to EXIT_VALUE -> readback 0x0000CC00.
REQ-037 SHALL cover: forced counter value 0x0000_0000_FFFF_FFFF, read CYCLE_LO then CYCLE_HI -> returned values are consistent (low 0xFFFFFFFF, high 0).
REQ-038 SHALL cover: reset asserted in the cycle after a granted read -> rvalid_o=0 and all registers read 0 after release.
